rcn_ring_port: RTL and testbench

RCN_RING_PORT -- requirements
Module: rcn_ring_port

---
 rtl/rcn_ring_port.sv | 100 ++++++++++
 tb/tb_rcn_ring_port.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rcn_ring_port.sv
// Ring network port: removes packets addressed to this node or orphaned after a full lap,
// injects local transmit packets into free slots, and flags injection starvation.
module rcn_ring_port #(
    parameter logic [5:0] NODE_ID      = 6'd0,
    parameter logic [7:0] STARVE_LIMIT = 8'd15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [68:0] ring_in,
    output logic [68:0] ring_out,
    input  logic [68:0] tx_data,
    input  logic        tx_empty,
    output logic        tx_pop,
    output logic [68:0] rx_data,
    output logic        rx_push,
    input  logic        rx_full,
    output logic        starved,
    output logic [7:0]  orphan_cnt
);

    // A limit of zero is treated as one so the starvation threshold stays reachable.
    localparam logic [7:0] LIMIT = (STARVE_LIMIT == 8'd0) ? 8'd1 : STARVE_LIMIT;

    typedef enum logic [1:0] {IDLE, WAIT, STARVED} state_t;

    state_t     state;
    logic [7:0] blk;
    logic [7:0] blk_inc;
    logic       match;
    logic       orphan;
    logic       slot_free;
    logic       blocked;

    assign match     = ring_in[68] && (ring_in[66:61] == NODE_ID);
    assign orphan    = ring_in[68] && !match && (ring_in[60:55] == NODE_ID);
    assign rx_push   = rst_n && match && !rx_full;
    assign rx_data   = ring_in;
    assign slot_free = !ring_in[68] || rx_push || orphan;
    assign blocked   = !slot_free;
    assign tx_pop    = rst_n && slot_free && !tx_empty && tx_data[68];
    assign blk_inc   = (blk >= LIMIT) ? LIMIT : blk + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ring_out   <= '0;
            orphan_cnt <= '0;
            state      <= IDLE;
            blk        <= '0;
            starved    <= 1'b0;
        end else begin
            ring_out <= tx_pop ? tx_data : (slot_free ? '0 : ring_in);
            if (orphan && orphan_cnt != 8'hFF)
                orphan_cnt <= orphan_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (!tx_empty && blocked) begin
                        blk <= 8'd1;
                        if (LIMIT == 8'd1) begin
                            state   <= STARVED;
                            starved <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        blk <= '0;
                    end
                end
                WAIT: begin
                    if (tx_pop || tx_empty) begin
                        state <= IDLE;
                        blk   <= '0;
                    end else begin
                        blk <= blk_inc;
                        // blk holds the blocked cycles already seen, so this is the LIMIT-th one
                        if (blocked && blk >= LIMIT - 8'd1) begin
                            state   <= STARVED;
                            starved <= 1'b1;
                        end
                    end
                end
                STARVED: begin
                    if (tx_pop || tx_empty) begin
                        state   <= IDLE;
                        blk     <= '0;
                        starved <= 1'b0;
                    end else begin
                        blk <= blk_inc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    blk     <= '0;
                    starved <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rcn_ring_port.sv
// Randomized and directed stimulus for rcn_ring_port; a behavioural model queues expectations
// and a negedge monitor pops and compares them.
module tb_rcn_ring_port;

    localparam logic [5:0] NID = 6'd3;

    logic        clk;
    logic        rst_n;
    logic [68:0] ring_in;
    logic [68:0] ring_out;
    logic [68:0] tx_data;
    logic        tx_empty;
    logic        tx_pop;
    logic [68:0] rx_data;
    logic        rx_push;
    logic        rx_full;
    logic        starved;
    logic [7:0]  orphan_cnt;

    rcn_ring_port #(.NODE_ID(NID), .STARVE_LIMIT(8'd15)) dut (
        .clk(clk), .rst_n(rst_n), .ring_in(ring_in), .ring_out(ring_out),
        .tx_data(tx_data), .tx_empty(tx_empty), .tx_pop(tx_pop),
        .rx_data(rx_data), .rx_push(rx_push), .rx_full(rx_full),
        .starved(starved), .orphan_cnt(orphan_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        push;
        logic        pop;
        logic [68:0] rxd;
        logic [68:0] ro;
        logic        st;
        logic [7:0]  cnt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Model state: register values the DUT should show after the most recent edge.
    logic [68:0] m_ro  = '0;
    logic        m_st  = 1'b0;
    logic [7:0]  m_cnt = '0;
    int          m_run = 0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rx_push",    69'(rx_push),    69'(e.push));
            chk("tx_pop",     69'(tx_pop),     69'(e.pop));
            chk("ring_out",   ring_out,        e.ro);
            chk("starved",    69'(starved),    69'(e.st));
            chk("orphan_cnt", 69'(orphan_cnt), 69'(e.cnt));
            if (e.push) chk("rx_data", rx_data, e.rxd);
        end
    end

    function automatic logic [68:0] pkt(input logic v, input logic [5:0] d, input logic [5:0] s);
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return {v, r[0], d, s, r[54:0]};
    endfunction

    // Drive one cycle of inputs (mid-cycle), queue the expectation, then advance the model.
    task automatic step(input logic [68:0] ri, input logic [68:0] td, input logic te,
                        input logic rf, input logic rs);
        logic m, o, push, free, pop;
        exp_t e;
        ring_in = ri; tx_data = td; tx_empty = te; rx_full = rf; rst_n = rs;
        m    = ri[68] && ri[66:61] == NID;
        o    = ri[68] && !m && ri[60:55] == NID;
        push = rs && m && !rf;
        free = !ri[68] || push || o;
        pop  = rs && free && !te && td[68];
        if (!rs) begin
            m_ro = '0; m_st = 1'b0; m_cnt = '0; m_run = 0;
        end
        e.push = push; e.pop = pop; e.rxd = ri;
        e.ro = m_ro; e.st = m_st; e.cnt = m_cnt;
        q.push_back(e);
        if (rs) begin
            m_ro = pop ? td : (free ? 69'd0 : ri);
            if (o && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            // Stimulus keeps tx_data valid when not empty, so pending-without-pop means blocked.
            if (te || pop) begin
                m_run = 0; m_st = 1'b0;
            end else begin
                if (m_run < 255) m_run++;
                if (m_run >= 15) m_st = 1'b1;
            end
        end
        @(posedge clk); #2;
    endtask

    initial begin
        logic [5:0] d, s;
        ring_in = '0; tx_data = '0; tx_empty = 1'b1; rx_full = 1'b0; rst_n = 1'b0;
        @(posedge clk); #2;
        // Reset: outputs forced low even with live traffic
        for (int i = 0; i < 3; i++)
            step(pkt(1'b1, NID, 6'd7), pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b0);
        // Match with rx space, with and without tx pending
        step(pkt(1'b1, NID, 6'd7), pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b1);
        step(pkt(1'b1, NID, 6'd8), '0, 1'b1, 1'b0, 1'b1);
        // Match with rx full: forwarded unchanged
        step(pkt(1'b1, NID, 6'd7), '0, 1'b1, 1'b1, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        // 300 orphans saturate the counter
        for (int i = 0; i < 300; i++)
            step(pkt(1'b1, 6'd5, NID), '0, 1'b1, 1'b0, 1'b1);
        // Starvation: 20 blocked cycles, then one free slot
        for (int i = 0; i < 20; i++)
            step(pkt(1'b1, 6'd7, 6'd9), pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b1);
        step('0, pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        // Empty ring drains four queued packets back to back
        for (int i = 0; i < 4; i++)
            step('0, pkt(1'b1, 6'(10 + i), NID), 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        // Reset pulse mid-injection, then resume
        step(pkt(1'b1, 6'd7, 6'd9), pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b1);
        step(pkt(1'b1, 6'd7, 6'd9), pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b0);
        step('0, pkt(1'b1, 6'd9, NID), 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b1);
        // Random traffic with occasional mid-stream resets
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: d = NID;
                1: d = 6'd5;
                default: d = 6'($urandom);
            endcase
            s = ($urandom_range(0, 2) == 0) ? NID : 6'($urandom);
            step(pkt($urandom_range(0, 4) != 0, d, s),
                 pkt(1'b1, 6'($urandom), NID),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 60) != 0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
